// File: rtl/min_pkg.sv
// Shared defaults, FSM encodings and candidate record for the min-search collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package min_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_IDX_X_WIDTH = 3;
    localparam int DEF_IDX_Y_WIDTH = 4;
    localparam int DEF_BEAT_NUM    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Candidate record at the default widths: value, x index, y index.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]  d;
        logic [DEF_IDX_X_WIDTH-1:0] x;
        logic [DEF_IDX_Y_WIDTH-1:0] y;
    } cand_t;

endpackage

// File: rtl/min_frame_collector_if.sv
// Beat input and frame-result output bundle of the min-search collector.
// Latency: n/a (wires only).
// Backpressure: in_ready is advisory only; result side is valid/ready.
interface min_frame_collector_if
    import min_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IDX_X_WIDTH = DEF_IDX_X_WIDTH,
    parameter int IDX_Y_WIDTH = DEF_IDX_Y_WIDTH,
    parameter int BEAT_NUM    = DEF_BEAT_NUM
);
    localparam int BEAT_WIDTH = $clog2(BEAT_NUM);

    logic                   in_val;
    logic                   in_last;
    logic                   cand_val;
    logic [DATA_WIDTH-1:0]  cand_d;
    logic [IDX_X_WIDTH-1:0] cand_x;
    logic [IDX_Y_WIDTH-1:0] cand_y;
    logic                   in_ready;
    logic                   out_val;
    logic                   out_ready;
    logic                   out_found;
    logic [DATA_WIDTH-1:0]  out_d;
    logic [IDX_X_WIDTH-1:0] out_x;
    logic [IDX_Y_WIDTH-1:0] out_y;
    logic [BEAT_WIDTH-1:0]  out_beat;
    logic [BEAT_WIDTH:0]    out_cnt;
    logic                   err_drop;

    // Upstream tree and result consumer side.
    modport master (
        output in_val, in_last, cand_val, cand_d, cand_x, cand_y, out_ready,
        input  in_ready, out_val, out_found, out_d, out_x, out_y, out_beat, out_cnt, err_drop
    );

    // Collector side.
    modport slave (
        input  in_val, in_last, cand_val, cand_d, cand_x, cand_y, out_ready,
        output in_ready, out_val, out_found, out_d, out_x, out_y, out_beat, out_cnt, err_drop
    );

endinterface

// File: rtl/min_cand_update.sv
// Decides whether an incoming candidate replaces the running best and forms the next best.
// Latency: combinational.
// Backpressure: none.
module min_cand_update
    import min_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IDX_X_WIDTH = DEF_IDX_X_WIDTH,
    parameter int IDX_Y_WIDTH = DEF_IDX_Y_WIDTH
) (
    input  logic                   have,
    input  logic [DATA_WIDTH-1:0]  best_d,
    input  logic [IDX_X_WIDTH-1:0] best_x,
    input  logic [IDX_Y_WIDTH-1:0] best_y,
    input  logic                   cand_val,
    input  logic [DATA_WIDTH-1:0]  cand_d,
    input  logic [IDX_X_WIDTH-1:0] cand_x,
    input  logic [IDX_Y_WIDTH-1:0] cand_y,
    output logic                   take,
    output logic [DATA_WIDTH-1:0]  nxt_d,
    output logic [IDX_X_WIDTH-1:0] nxt_x,
    output logic [IDX_Y_WIDTH-1:0] nxt_y
);

    // Strict less-than so the earliest beat keeps a tie.
    always_comb begin
        take  = cand_val & (~have | (cand_d < best_d));
        nxt_d = take ? cand_d : best_d;
        nxt_x = take ? cand_x : best_x;
        nxt_y = take ? cand_y : best_y;
    end

endmodule

// File: rtl/min_frame_collector.sv
// Tracks the running minimum over a frame of beats and presents frame min, beat index and count.
// Latency: result valid the cycle after the closing beat is accepted.
// Backpressure: result held until out_ready; beats arriving while held are dropped and flagged.
module min_frame_collector
    import min_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IDX_X_WIDTH = DEF_IDX_X_WIDTH,
    parameter int IDX_Y_WIDTH = DEF_IDX_Y_WIDTH,
    parameter int BEAT_NUM    = DEF_BEAT_NUM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    min_frame_collector_if.slave bus
);

    localparam int BEAT_WIDTH = $clog2(BEAT_NUM);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEAT_NUM - 1);
    localparam logic [BEAT_WIDTH-1:0] BEAT_ONE  = BEAT_WIDTH'(1);
    localparam logic [BEAT_WIDTH:0]   CNT_ONE   = (BEAT_WIDTH + 1)'(1);

    state_t                 state_q, state_d;
    logic [BEAT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                   have_q, have_d;
    logic [DATA_WIDTH-1:0]  best_val_q, best_val_d;
    logic [IDX_X_WIDTH-1:0] best_x_q, best_x_d;
    logic [IDX_Y_WIDTH-1:0] best_y_q, best_y_d;
    logic [BEAT_WIDTH-1:0]  best_beat_q, best_beat_d;
    logic [BEAT_WIDTH:0]    cnt_q, cnt_d;
    logic                   err_drop_q, err_drop_d;

    logic                   in_ready;
    logic                   accept;
    logic                   close;
    logic                   take;
    logic [DATA_WIDTH-1:0]  nxt_d;
    logic [IDX_X_WIDTH-1:0] nxt_x;
    logic [IDX_Y_WIDTH-1:0] nxt_y;

    assign in_ready = (state_q != ST_HOLD);
    assign accept   = bus.in_val & in_ready;
    assign close    = bus.in_last | (beat_cnt_q == LAST_BEAT);

    min_cand_update #(
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_X_WIDTH (IDX_X_WIDTH),
        .IDX_Y_WIDTH (IDX_Y_WIDTH)
    ) u_upd (
        .have     (have_q),
        .best_d   (best_val_q),
        .best_x   (best_x_q),
        .best_y   (best_y_q),
        .cand_val (bus.cand_val),
        .cand_d   (bus.cand_d),
        .cand_x   (bus.cand_x),
        .cand_y   (bus.cand_y),
        .take     (take),
        .nxt_d    (nxt_d),
        .nxt_x    (nxt_x),
        .nxt_y    (nxt_y)
    );

    // Next-state: accumulate accepted beats, close into HOLD, clear running state on transfer.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        have_d      = have_q;
        best_val_d  = best_val_q;
        best_x_d    = best_x_q;
        best_y_d    = best_y_q;
        best_beat_d = best_beat_q;
        cnt_d       = cnt_q;
        err_drop_d  = err_drop_q | (bus.in_val & ~in_ready);
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    if (take) begin
                        have_d      = 1'b1;
                        best_val_d  = nxt_d;
                        best_x_d    = nxt_x;
                        best_y_d    = nxt_y;
                        best_beat_d = beat_cnt_q;
                    end
                    if (bus.cand_val) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (close) begin
                        state_d    = ST_HOLD;
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = ST_ACCUM;
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    have_d      = 1'b0;
                    best_val_d  = '0;
                    best_x_d    = '0;
                    best_y_d    = '0;
                    best_beat_d = '0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset discards any frame in progress or held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            have_q      <= 1'b0;
            best_val_q  <= '0;
            best_x_q    <= '0;
            best_y_q    <= '0;
            best_beat_q <= '0;
            cnt_q       <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            have_q      <= have_d;
            best_val_q  <= best_val_d;
            best_x_q    <= best_x_d;
            best_y_q    <= best_y_d;
            best_beat_q <= best_beat_d;
            cnt_q       <= cnt_d;
            err_drop_q  <= err_drop_d;
        end
    end

    // Running registers double as the result; they are zero whenever nothing was found.
    assign bus.in_ready  = in_ready;
    assign bus.out_val   = (state_q == ST_HOLD);
    assign bus.out_found = have_q;
    assign bus.out_d     = best_val_q;
    assign bus.out_x     = best_x_q;
    assign bus.out_y     = best_y_q;
    assign bus.out_beat  = best_beat_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.err_drop  = err_drop_q;

endmodule

// File: tb/tb_min_frame_collector.sv
// Scoreboard bench for min_frame_collector: frames pushed as driven, results popped on out_val.
// Latency: checks result one cycle after closing beat where the scenario requires it.
// Backpressure: exercises held results and dropped beats.
module tb_min_frame_collector;
    import min_pkg::*;

    typedef struct packed {
        logic       found;
        logic [7:0] d;
        logic [2:0] x;
        logic [3:0] y;
        logic [3:0] beat;
        logic [4:0] cnt;
    } res_t;

    typedef struct packed {
        logic  cv;
        cand_t c;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    min_frame_collector_if bus ();

    min_frame_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t beats[$];
    res_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Expected result of the frame held in beats: earliest strict minimum among valid candidates.
    function automatic res_t model_frame();
        res_t r = '0;
        foreach (beats[i]) begin
            if (beats[i].cv) begin
                r.cnt = r.cnt + 5'd1;
                if (!r.found || beats[i].c.d < r.d) begin
                    r.found = 1'b1;
                    r.d     = beats[i].c.d;
                    r.x     = beats[i].c.x;
                    r.y     = beats[i].c.y;
                    r.beat  = 4'(i);
                end
            end
        end
        return r;
    endfunction

    function automatic res_t pop_exp();
        res_t r = '0;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        return r;
    endfunction

    task automatic idle_inputs();
        bus.in_val    = 1'b0;
        bus.in_last   = 1'b0;
        bus.cand_val  = 1'b0;
        bus.cand_d    = '0;
        bus.cand_x    = '0;
        bus.cand_y    = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic send(input logic last, input logic cv, input logic [7:0] d,
                        input logic [2:0] x, input logic [3:0] y);
        beat_t b;
        bus.in_val   = 1'b1;
        bus.in_last  = last;
        bus.cand_val = cv;
        bus.cand_d   = d;
        bus.cand_x   = x;
        bus.cand_y   = y;
        b.cv = cv; b.c.d = d; b.c.x = x; b.c.y = y;
        beats.push_back(b);
        @(posedge clk); #1;
        bus.in_val  = 1'b0;
        bus.in_last = 1'b0;
        if (last || beats.size() == 16) begin
            exp_q.push_back(model_frame());
            beats.delete();
        end
    endtask

    task automatic await_out(input int budget, output res_t got, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.out_val === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        got = {bus.out_found, bus.out_d, bus.out_x, bus.out_y, bus.out_beat, bus.out_cnt};
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_val, bus.out_found, bus.out_d, bus.out_x, bus.out_y, bus.out_beat,
             bus.out_cnt, bus.err_drop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: val=%b found=%b d=%0d cnt=%0d err=%b, required all 0",
                     bus.out_val, bus.out_found, bus.out_d, bus.out_cnt, bus.err_drop);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_val=%b, required 1/0", bus.in_ready, bus.out_val);
        end
        // Partial frame then reset mid-ACCUM.
        send(1'b0, 1'b1, 8'd5, 3'd1, 4'd1);
        send(1'b0, 1'b1, 8'd2, 3'd2, 4'd2);
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.out_val !== 1'b0 || bus.out_cnt !== 5'd0 || bus.out_found !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: out_val=%b out_cnt=%0d found=%b, required 0/0/0",
                     bus.out_val, bus.out_cnt, bus.out_found);
        end
        beats.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_val !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_no_out_val: out_val rose after mid-frame reset, required 0");
        end
    endtask

    task automatic test_ties();
        res_t got, exp;
        bit ok;
        logic [7:0] dv [4] = '{8'd40, 8'd12, 8'd12, 8'd90};
        for (int i = 0; i < 4; i++)
            send(i == 3, 1'b1, dv[i], 3'(i + 1), 4'(i + 6));
        await_out(1, got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ties_latency: out_val=0 one cycle after closing beat, required 1");
        end else if (got !== exp) begin
            n_fail++;
            $display("FAIL ties_result: got %p, required %p", got, exp);
        end
        n_checks++;
        if ({got.found, got.d, got.beat, got.cnt} !== {1'b1, 8'd12, 4'd1, 5'd4}) begin
            n_fail++;
            $display("FAIL ties_first_wins: found=%b d=%0d beat=%0d cnt=%0d, required 1/12/1/4",
                     got.found, got.d, got.beat, got.cnt);
        end
        release_out();
    endtask

    task automatic test_auto_close();
        res_t got, exp;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            if (i == 15)     send(1'b0, 1'b1, 8'd3, 3'd5, 4'd9);
            else if (i == 7) send(1'b0, 1'b1, 8'd4, 3'd1, 4'd1);
            else             send(1'b0, 1'b1, 8'(100 + i * 7), 3'(i), 4'(i));
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_close_ready: in_ready=%b after beat 15, required 0", bus.in_ready);
        end
        await_out(1, got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL auto_close_timeout: out_val=0 after beat 15, required 1");
        end else if (got !== exp) begin
            n_fail++;
            $display("FAIL auto_close_result: got %p, required %p", got, exp);
        end
        n_checks++;
        if ({got.d, got.x, got.y, got.beat, got.cnt} !== {8'd3, 3'd5, 4'd9, 4'd15, 5'd16}) begin
            n_fail++;
            $display("FAIL auto_close_fields: d=%0d x=%0d y=%0d beat=%0d cnt=%0d, required 3/5/9/15/16",
                     got.d, got.x, got.y, got.beat, got.cnt);
        end
        release_out();
    endtask

    task automatic test_no_cand();
        res_t got, exp;
        bit ok;
        for (int i = 0; i < 3; i++)
            send(i == 2, 1'b0, 8'(i + 1), 3'(i + 2), 4'(i + 3));
        await_out(4, got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL no_cand_timeout: out_val never rose, required 1");
        end else if (got !== exp || got !== '0) begin
            n_fail++;
            $display("FAIL no_cand_result: got %p, required all zero", got);
        end
        release_out();
    endtask

    task automatic test_hold_drop();
        res_t got, exp, now;
        bit ok;
        send(1'b0, 1'b1, 8'd50, 3'd1, 4'd1);
        send(1'b1, 1'b1, 8'd20, 3'd2, 4'd3);
        await_out(4, got, ok);
        exp = pop_exp();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_timeout: out_val never rose, required 1");
        end
        for (int c = 0; c < 5; c++) begin
            bus.in_val   = 1'b1;
            bus.in_last  = c[0];
            bus.cand_val = 1'b1;
            bus.cand_d   = 8'(c);
            bus.cand_x   = 3'(c);
            bus.cand_y   = 4'(c);
            @(posedge clk); #1;
            now = {bus.out_found, bus.out_d, bus.out_x, bus.out_y, bus.out_beat, bus.out_cnt};
            n_checks++;
            if (now !== exp || bus.out_val !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable_%0d: got %p val=%b rdy=%b, required %p val=1 rdy=0",
                         c, now, bus.out_val, bus.in_ready, exp);
            end
        end
        idle_inputs();
        n_checks++;
        if (bus.err_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_err_drop: err_drop=%b, required 1", bus.err_drop);
        end
        release_out();
        n_checks++;
        if (bus.err_drop !== 1'b1 || bus.out_val !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_after_xfer: err=%b val=%b rdy=%b, required 1/0/1",
                     bus.err_drop, bus.out_val, bus.in_ready);
        end
    endtask

    task automatic test_single();
        res_t got, exp;
        bus.out_ready = 1'b1;
        send(1'b1, 1'b1, 8'd7, 3'd3, 4'd4);
        got = {bus.out_found, bus.out_d, bus.out_x, bus.out_y, bus.out_beat, bus.out_cnt};
        exp = pop_exp();
        n_checks++;
        if (bus.out_val !== 1'b1 || bus.in_ready !== 1'b0 || got !== exp) begin
            n_fail++;
            $display("FAIL single_latency: val=%b rdy=%b got %p, required val=1 rdy=0 %p",
                     bus.out_val, bus.in_ready, got, exp);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_val !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_bubble: val=%b rdy=%b after transfer, required 0/1",
                     bus.out_val, bus.in_ready);
        end
        send(1'b1, 1'b1, 8'd9, 3'd6, 4'd11);
        got = {bus.out_found, bus.out_d, bus.out_x, bus.out_y, bus.out_beat, bus.out_cnt};
        exp = pop_exp();
        n_checks++;
        if (bus.out_val !== 1'b1 || got !== exp) begin
            n_fail++;
            $display("FAIL single_next_frame: val=%b got %p, required val=1 %p", bus.out_val, got, exp);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.err_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL single_err_sticky: err_drop=%b, required 1", bus.err_drop);
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        bit ok;
        int len;
        for (int f = 0; f < 8; f++) begin
            len = (f == 0) ? 16 : $urandom_range(1, 16);
            for (int i = 0; i < len; i++)
                send((i == len - 1) && (len < 16 || f[0]), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 31)), 3'($urandom), 4'($urandom));
            await_out(2, got, ok);
            exp = pop_exp();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_timeout_%0d: out_val never rose, required 1", f);
            end else if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b_result_%0d: got %p, required %p", f, got, exp);
            end
            release_out();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ties();
        test_auto_close();
        test_no_cand();
        test_hold_drop();
        test_single();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
